// File: rtl/gpi_bank_pkg.sv
// gpi_bank_pkg: register map offsets, port request type and read mux shared by the input bank
//   NUM_OFF       number of one-hot offsets per port
//   OFF_*         first offset of each register group
//   port_req_t    one I2C slave channel's access request
//   reg_map_t     all readable bytes indexed by offset
package gpi_bank_pkg;

    localparam int NUM_OFF   = 16;
    localparam int OFF_STAT0 = 0;
    localparam int OFF_CHG0  = 4;
    localparam int OFF_MASK0 = 8;
    localparam int OFF_SUM   = 12;

    typedef struct packed {
        logic        cs;
        logic        rd;
        logic [15:0] sel;
        logic [7:0]  din;
    } port_req_t;

    typedef logic [NUM_OFF-1:0][7:0] reg_map_t;

    function automatic logic wr_hit(port_req_t p, int k);
        return p.cs & ~p.rd & p.sel[k];
    endfunction

    // AND-OR mux; a one-hot select returns exactly one byte
    function automatic logic [7:0] rd_mux(logic [15:0] sel, reg_map_t regs);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < NUM_OFF; k++)
            r |= sel[k] ? regs[k] : 8'h00;
        return r;
    endfunction

endpackage

// File: rtl/gpi_debounce.sv
// gpi_debounce: synchronizer, tick-sampled debounce counter and debounced level for one board input
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   di_i    asynchronous input
//   tick_i  one-cycle sample strobe
//   stat_o  debounced level
//   set_o   one-cycle pulse on the edge where stat_o toggles
module gpi_debounce #(
    parameter int unsigned DEB_CNT = 3,
    parameter logic        GPI_DFT = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic di_i,
    input  logic tick_i,
    output logic stat_o,
    output logic set_o
);

    localparam logic [2:0] LAST = 3'(DEB_CNT - 1);

    logic [1:0] sync_q;
    logic [2:0] cnt_q, cnt_d;
    logic       stat_q, differs;

    assign differs = sync_q[1] ^ stat_q;
    // the tick that would bring the count to DEB_CNT flips the level directly
    assign set_o   = tick_i & differs & (cnt_q == LAST);
    assign stat_o  = stat_q;

    always_comb cnt_d = !tick_i ? cnt_q : (!differs || set_o) ? 3'd0 : cnt_q + 3'd1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {2{GPI_DFT}};
            cnt_q  <= '0;
            stat_q <= GPI_DFT;
        end else begin
            sync_q <= {sync_q[0], di_i};
            cnt_q  <= cnt_d;
            stat_q <= stat_q ^ set_o;
        end
    end

endmodule

// File: rtl/gpi_bank.sv
// gpi_bank: 32-input debounced status bank with sticky change bits, interrupt mask and dual-port register access
//   SYSCLK, RESET                 clock and synchronous active-high reset
//   PORT_CSx, OFFSET_SELx, RD_WRx channel x select, one-hot offset, 1=read 0=write
//   DINx / DOUTx                  channel x write data / registered read data
//   DI                            asynchronous board inputs
//   INT_N                         registered active-low interrupt
module gpi_bank
    import gpi_bank_pkg::*;
#(
    parameter logic [31:0] GPI_DFT  = 32'h0,
    parameter logic [15:0] TICK_DIV = 16'd1000,
    parameter int unsigned DEB_CNT  = 3
) (
    input  logic        SYSCLK,
    input  logic        RESET,
    input  logic        PORT_CS1,
    input  logic        PORT_CS2,
    input  logic [15:0] OFFSET_SEL1,
    input  logic [15:0] OFFSET_SEL2,
    input  logic        RD_WR1,
    input  logic        RD_WR2,
    input  logic [7:0]  DIN1,
    input  logic [7:0]  DIN2,
    output logic [7:0]  DOUT1,
    output logic [7:0]  DOUT2,
    input  logic [31:0] DI,
    output logic        INT_N
);

    port_req_t   p1, p2;
    logic [15:0] presc_q, presc_d;
    logic        tick;
    logic [31:0] stat, set;
    logic [31:0] chg_q, chg_d, mask_q, mask_d, clr;
    logic [3:0]  sum;
    reg_map_t    regs;
    logic [7:0]  dout1_q, dout2_q;
    logic        int_n_q;

    assign p1 = '{cs: PORT_CS1, rd: RD_WR1, sel: OFFSET_SEL1, din: DIN1};
    assign p2 = '{cs: PORT_CS2, rd: RD_WR2, sel: OFFSET_SEL2, din: DIN2};

    assign tick    = presc_q == TICK_DIV - 16'd1;
    assign presc_d = tick ? '0 : presc_q + 16'd1;

    for (genvar g = 0; g < 32; g++) begin : g_deb
        gpi_debounce #(.DEB_CNT(DEB_CNT), .GPI_DFT(GPI_DFT[g])) u_deb (
            .clk_i  (SYSCLK),
            .rst_i  (RESET),
            .di_i   (DI[g]),
            .tick_i (tick),
            .stat_o (stat[g]),
            .set_o  (set[g])
        );
    end

    always_comb begin
        clr    = '0;
        mask_d = mask_q;
        sum    = '0;
        for (int n = 0; n < 4; n++) begin
            clr[8*n +: 8] = (wr_hit(p1, OFF_CHG0 + n) ? p1.din : 8'h00) |
                            (wr_hit(p2, OFF_CHG0 + n) ? p2.din : 8'h00);
            // port 1 is applied last so it wins a same-byte collision
            if (wr_hit(p2, OFF_MASK0 + n)) mask_d[8*n +: 8] = p2.din;
            if (wr_hit(p1, OFF_MASK0 + n)) mask_d[8*n +: 8] = p1.din;
            sum[n] = |(chg_q[8*n +: 8] & mask_q[8*n +: 8]);
        end
        // a new event outranks a simultaneous clear
        chg_d = (chg_q & ~clr) | set;
        regs  = {24'h0, {4'h0, sum}, mask_q, chg_q, stat};
    end

    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            presc_q <= '0;
            chg_q   <= '0;
            mask_q  <= '0;
            dout1_q <= '0;
            dout2_q <= '0;
            int_n_q <= 1'b1;
        end else begin
            presc_q <= presc_d;
            chg_q   <= chg_d;
            mask_q  <= mask_d;
            dout1_q <= (p1.cs & p1.rd) ? rd_mux(p1.sel, regs) : dout1_q;
            dout2_q <= (p2.cs & p2.rd) ? rd_mux(p2.sel, regs) : dout2_q;
            int_n_q <= ~|(chg_q & mask_q);
        end
    end

    assign DOUT1 = dout1_q;
    assign DOUT2 = dout2_q;
    assign INT_N = int_n_q;

endmodule

// File: tb/tb_gpi_bank.sv
// tb_gpi_bank: directed and random checks of gpi_bank against a behavioural register-bank model
module tb_gpi_bank;

    localparam int TD = 4;
    localparam int DC = 3;

    logic        SYSCLK = 1'b0;
    logic        RESET = 1'b1;
    logic        PORT_CS1 = 1'b0, PORT_CS2 = 1'b0, RD_WR1 = 1'b0, RD_WR2 = 1'b0;
    logic [15:0] OFFSET_SEL1 = '0, OFFSET_SEL2 = '0;
    logic [7:0]  DIN1 = '0, DIN2 = '0, DOUT1, DOUT2;
    logic [31:0] DI = '0;
    logic        INT_N;

    int checks = 0;
    int errors = 0;

    gpi_bank #(.GPI_DFT(32'h0), .TICK_DIV(16'd4), .DEB_CNT(3)) dut (
        .SYSCLK      (SYSCLK),
        .RESET       (RESET),
        .PORT_CS1    (PORT_CS1),
        .PORT_CS2    (PORT_CS2),
        .OFFSET_SEL1 (OFFSET_SEL1),
        .OFFSET_SEL2 (OFFSET_SEL2),
        .RD_WR1      (RD_WR1),
        .RD_WR2      (RD_WR2),
        .DIN1        (DIN1),
        .DIN2        (DIN2),
        .DOUT1       (DOUT1),
        .DOUT2       (DOUT2),
        .DI          (DI),
        .INT_N       (INT_N)
    );

    always #5 SYSCLK = ~SYSCLK;

    // reference model: whole-word registers, a 2-cycle input delay line and a per-bit run length
    logic [31:0] m_stat, m_chg, m_mask, m_s1, m_s2;
    int          m_cyc;
    int          m_run [32];
    logic [7:0]  m_dout1, m_dout2;
    logic        m_int_n;

    function automatic logic [7:0] m_byte(int k);
        logic [7:0] s;
        s = '0;
        if (k < 4) return m_stat[8*k +: 8];
        if (k < 8) return m_chg[8*(k-4) +: 8];
        if (k < 12) return m_mask[8*(k-8) +: 8];
        if (k == 12) begin
            for (int n = 0; n < 4; n++) s[n] = |(m_chg[8*n +: 8] & m_mask[8*n +: 8]);
        end
        return s;
    endfunction

    function automatic logic [7:0] m_read(logic [15:0] sel);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) if (sel[k]) r |= m_byte(k);
        return r;
    endfunction

    function automatic logic will_set(int i);
        return (m_cyc % TD == TD - 1) && (m_s2[i] != m_stat[i]) && (m_run[i] == DC - 1);
    endfunction

    task automatic model_update();
        logic [31:0] set, clr, nmask;
        logic [7:0]  n1, n2;
        logic        nint;
        if (RESET) begin
            m_stat = '0; m_chg = '0; m_mask = '0; m_s1 = '0; m_s2 = '0; m_cyc = 0;
            for (int i = 0; i < 32; i++) m_run[i] = 0;
            m_dout1 = '0; m_dout2 = '0; m_int_n = 1'b1;
            return;
        end
        set = '0;
        if (m_cyc % TD == TD - 1) begin
            for (int i = 0; i < 32; i++) begin
                if (m_s2[i] != m_stat[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC) begin set[i] = 1'b1; m_run[i] = 0; end
                end else m_run[i] = 0;
            end
        end
        m_cyc++;
        n1 = (PORT_CS1 && RD_WR1) ? m_read(OFFSET_SEL1) : m_dout1;
        n2 = (PORT_CS2 && RD_WR2) ? m_read(OFFSET_SEL2) : m_dout2;
        nint = ~|(m_chg & m_mask);
        clr = '0;
        nmask = m_mask;
        for (int n = 0; n < 4; n++) begin
            if (PORT_CS1 && !RD_WR1 && OFFSET_SEL1[4+n]) clr[8*n +: 8] |= DIN1;
            if (PORT_CS2 && !RD_WR2 && OFFSET_SEL2[4+n]) clr[8*n +: 8] |= DIN2;
            if (PORT_CS2 && !RD_WR2 && OFFSET_SEL2[8+n]) nmask[8*n +: 8] = DIN2;
            if (PORT_CS1 && !RD_WR1 && OFFSET_SEL1[8+n]) nmask[8*n +: 8] = DIN1;
        end
        m_stat  = m_stat ^ set;
        m_chg   = (m_chg & ~clr) | set;
        m_mask  = nmask;
        m_dout1 = n1;
        m_dout2 = n2;
        m_int_n = nint;
        m_s2    = m_s1;
        m_s1    = DI;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge SYSCLK);
        model_update();
        @(negedge SYSCLK);
        chk("dout1", DOUT1, m_dout1);
        chk("dout2", DOUT2, m_dout2);
        chk("int_n", INT_N, m_int_n);
    endtask

    task automatic port1(input logic cs, input logic rd, input int off, input logic [7:0] d);
        PORT_CS1 = cs; RD_WR1 = rd; OFFSET_SEL1 = 16'h1 << off; DIN1 = d;
    endtask

    task automatic port2(input logic cs, input logic rd, input int off, input logic [7:0] d);
        PORT_CS2 = cs; RD_WR2 = rd; OFFSET_SEL2 = 16'h1 << off; DIN2 = d;
    endtask

    task automatic idle();
        PORT_CS1 = 1'b0; PORT_CS2 = 1'b0;
    endtask

    task automatic rd1_chk(input int off, input logic [7:0] exp, input string tag);
        port1(1'b1, 1'b1, off, 8'h00);
        step();
        idle();
        chk(tag, DOUT1, exp);
    endtask

    initial begin
        logic found;
        int   lat, b;
        repeat (2) step();
        chk("rst_dout1", DOUT1, 8'h00);
        chk("rst_int_n", INT_N, 1'b1);
        RESET = 1'b0;

        rd1_chk(0, 8'h00, "t1_stat0");
        rd1_chk(4, 8'h00, "t1_chg0");
        rd1_chk(8, 8'h00, "t1_mask0");
        rd1_chk(12, 8'h00, "t1_sum");
        chk("t1_int_n", INT_N, 1'b1);

        DI[0] = 1'b1;
        found = 1'b0;
        lat = 0;
        for (int n = 1; n <= 30 && !found; n++) begin
            port1(1'b1, 1'b1, 0, 8'h00);
            step();
            if (DOUT1 == 8'h01) begin found = 1'b1; lat = n - 1; end
        end
        idle();
        chk("t2_stat0_seen", found, 1'b1);
        chk("t2_latency_in_11_14", (lat >= 11 && lat <= 14), 1'b1);
        rd1_chk(4, 8'h01, "t2_chg0");
        chk("t2_int_masked", INT_N, 1'b1);
        port1(1'b1, 1'b0, 8, 8'h01);
        step();
        idle();
        chk("t2_int_same_cycle", INT_N, 1'b1);
        step();
        chk("t2_int_asserted", INT_N, 1'b0);
        rd1_chk(12, 8'h01, "t2_sum");

        DI[9] = 1'b1;
        repeat (6) step();
        DI[9] = 1'b0;
        repeat (24) step();
        rd1_chk(1, 8'h00, "t3_stat1");
        rd1_chk(5, 8'h00, "t3_chg1");

        DI[0] = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 30 && !found; n++) begin
            if (will_set(0)) begin
                port1(1'b1, 1'b0, 4, 8'h01);
                found = 1'b1;
            end
            step();
            idle();
        end
        chk("t4_collision_hit", found, 1'b1);
        rd1_chk(4, 8'h01, "t4_chg0_kept");
        rd1_chk(0, 8'h00, "t4_stat0");

        port1(1'b1, 1'b0, 10, 8'hAA);
        port2(1'b1, 1'b0, 10, 8'h55);
        step();
        idle();
        port1(1'b1, 1'b1, 10, 8'h00);
        port2(1'b1, 1'b1, 8, 8'h00);
        step();
        idle();
        chk("t5_mask2_p1_wins", DOUT1, 8'hAA);
        chk("t5_p2_mask0", DOUT2, 8'h01);
        port1(1'b1, 1'b0, 9, 8'h3C);
        port2(1'b1, 1'b1, 9, 8'h00);
        step();
        idle();
        chk("t5_read_pre_write", DOUT2, 8'h00);
        port2(1'b1, 1'b1, 9, 8'h00);
        step();
        idle();
        chk("t5_read_post_write", DOUT2, 8'h3C);

        DI[31] = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            step();
            if (m_run[31] == 2) found = 1'b1;
        end
        chk("t6_mid_debounce", found, 1'b1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        found = 1'b0;
        lat = 0;
        for (int n = 1; n <= 30 && !found; n++) begin
            port1(1'b1, 1'b1, 3, 8'h00);
            step();
            if (n == 1) chk("t6_stat3_after_reset", DOUT1, 8'h00);
            if (DOUT1 == 8'h80) begin found = 1'b1; lat = n - 1; end
        end
        idle();
        chk("t6_stat3_seen", found, 1'b1);
        chk("t6_full_debounce", lat, 12);
        rd1_chk(7, 8'h80, "t6_chg3");
        chk("t6_int_n", INT_N, 1'b1);

        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(3) == 0) begin
                b = int'($urandom_range(31));
                DI[b] = ~DI[b];
            end
            port1(1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(15)), 8'($urandom));
            port2(1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(15)), 8'($urandom));
            step();
        end
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
